// File: rtl/rams_arb_pkg.sv
// Shared types and default sizes for the round-robin RAM arbiter.
package rams_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;

endpackage

// File: rtl/rams_sp_core.sv
// Single-port read-first block RAM with a registered, synchronously resettable output.
module rams_sp_core #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= di;
      if (rst) dout <= '0;
      else     dout <= mem[addr];
    end
  end

endmodule

// File: rtl/rams_sp_rr_arbiter.sv
// Clears the shared RAM after reset, then grants one requester per cycle in rotation.
//   state   | meaning
//   ST_INIT | sweeping zeros into every RAM address, no grants
//   ST_RUN  | round-robin arbitration of client accesses
module rams_sp_rr_arbiter
  import rams_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      init_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               gnt_any;

  logic               mux_we;
  logic [ADDR_W-1:0]  mux_addr;
  logic [DATA_W-1:0]  mux_di;

  logic               ram_en;
  logic               ram_we;
  logic               ram_rst;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_di;

  // Search starts one past the last winner so a held request cannot starve others.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (state == ST_RUN) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    mux_we   = 1'b0;
    mux_addr = '0;
    mux_di   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mux_we   = we[i];
        mux_addr = addr[i*ADDR_W +: ADDR_W];
        mux_di   = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Holding the output reset during rst_n makes rdata read zero from the first reset edge.
  always_comb begin
    ram_en   = 1'b1;
    ram_we   = 1'b0;
    ram_rst  = 1'b1;
    ram_addr = cnt;
    ram_di   = '0;
    if (rst_n) begin
      if (state == ST_INIT) begin
        ram_we = 1'b1;
      end else begin
        ram_en   = gnt_any;
        ram_we   = mux_we;
        ram_rst  = gnt_any & mux_we;
        ram_addr = mux_addr;
        ram_di   = mux_di;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      rvalid    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (gnt_any) ptr <= gnt_idx;
          rvalid <= gnt & ~we;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  rams_sp_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .rst  (ram_rst),
    .addr (ram_addr),
    .di   (ram_di),
    .dout (rdata)
  );

endmodule
